// File: rtl/core_output_scheduler_if.sv
// Core-result bus and chunk output stream of core_output_scheduler.
// master = scheduler side, slave = cores plus downstream consumer.
interface core_output_scheduler_if #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_SIZE = 4,
    parameter int WIDTH      = 16
);
    localparam int CW = WIDTH * CHUNK_SIZE;
    localparam int IW = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]    core_valid;
    logic [CW*NUM_CORES-1:0] in;
    logic                    core_ack;
    logic [CW-1:0]           out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [IW-1:0]           out_core_idx;
    logic                    out_last;

    modport master (
        input  core_valid, in, out_ready,
        output core_ack, out_data, out_valid, out_core_idx, out_last
    );

    modport slave (
        output core_valid, in, out_ready,
        input  core_ack, out_data, out_valid, out_core_idx, out_last
    );
endinterface

// File: rtl/core_output_scheduler.sv
// Captures the full multi-core result bus once all cores are valid, then drains it chunk by chunk.
// Optional overrun detection (err port) is built when SCHED_OVR_CHECK_EN is defined.
module core_output_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_SIZE = 4,
    parameter int WIDTH      = 16,
    parameter int NUM_TILES  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    core_output_scheduler_if.master       bus,
    output logic                          busy,
    output logic                          done,
`ifdef SCHED_OVR_CHECK_EN
    output logic                          err,
`endif
    output logic [1:0]                    dbg_state
);
    localparam int CW = WIDTH * CHUNK_SIZE;
    localparam int IW = $clog2(NUM_CORES);
    localparam int TW = $clog2(NUM_TILES) + 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CORES - 1);
    localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Output handshake: a chunk moves on any rising clk edge where out_valid and out_ready
    // are both high; out_valid stays high and out_data/out_core_idx/out_last hold until then.

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IW-1:0]                 r_idx;
    logic [IW-1:0]                 w_idx_nxt;
    logic [TW-1:0]                 r_tile_cnt;
    logic [TW-1:0]                 w_tile_nxt;
    logic [NUM_CORES-1:0][CW-1:0]  r_cap;
    logic                          r_ack;
    logic                          w_capture;
    logic                          w_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tile_nxt  = r_tile_cnt;
        w_capture   = 1'b0;
        w_hs        = (r_state == S_DRAIN) && bus.out_ready;
        case (r_state)
            S_IDLE: begin
                w_idx_nxt  = '0;
                w_tile_nxt = '0;
                if (start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only a complete set of core results is captured; partial sets keep waiting.
                if (&bus.core_valid) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_hs) begin
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt = r_idx + 1'b1;
                    end else if (r_tile_cnt != LAST_TILE) begin
                        w_tile_nxt  = r_tile_cnt + 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_tile_cnt <= '0;
            r_ack      <= 1'b0;
            r_cap      <= '0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_tile_cnt <= w_tile_nxt;
            r_ack      <= w_capture;
            if (w_capture) begin
                r_cap <= bus.in;
            end
        end
    end

    // Outputs are gated by state so reset (and IDLE/WAIT) presents an all-zero stream.
    always_comb begin
        bus.core_ack     = r_ack;
        bus.out_valid    = (r_state == S_DRAIN);
        bus.out_data     = '0;
        bus.out_core_idx = '0;
        bus.out_last     = 1'b0;
        if (r_state == S_DRAIN) begin
            bus.out_data     = r_cap[r_idx];
            bus.out_core_idx = r_idx;
            bus.out_last     = (r_idx == LAST_IDX) && (r_tile_cnt == LAST_TILE);
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

`ifdef SCHED_OVR_CHECK_EN
    logic [NUM_CORES-1:0] r_cv_prev;
    logic                 r_err;

    // A core raising valid while its previous result is still draining would be overwritten later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cv_prev <= '0;
            r_err     <= 1'b0;
        end else begin
            r_cv_prev <= bus.core_valid;
            if ((r_state == S_DRAIN) && (|(bus.core_valid & ~r_cv_prev))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif
endmodule

// File: doc/core_output_scheduler.md
# core_output_scheduler

Sequences the wide multi-core result bus of the matrix-multiply array onto a single chunk-wide output stream. It waits for every MAC core to present a result, captures the full bus in one cycle, and acknowledges the cores. It then drains the captured bus one core-chunk at a time, in core order, under a valid/ready handshake. It repeats this for a programmed number of tiles per matrix and flags the last chunk and completion.

## Interface
- NUM_CORES, 4: number of MAC cores sharing the output stream; must be ≥2.
- CHUNK_SIZE, 4: elements per core result.
- WIDTH, 16: bits per element.
- NUM_TILES, 8: capture rounds per matrix; must be ≥1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a matrix; sampled in IDLE only.
- core_valid  in  NUM_CORES  per-core result-valid; bit i belongs to core i.
- in  in  WIDTH*CHUNK_SIZE*NUM_CORES  core results; core i occupies bits [(i+1)*WIDTH*CHUNK_SIZE-1 -: WIDTH*CHUNK_SIZE].
- core_ack  out  1  one-cycle pulse on capture; cores may drop or replace results afterwards.
- out_data  out  WIDTH*CHUNK_SIZE  current chunk.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_core_idx  out  $clog2(NUM_CORES)  core index of the current chunk.
- out_last  out  1  high with the final chunk of the final tile.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the final chunk is accepted.
- err  out  1  sticky overrun flag; present only with SCHED_OVR_CHECK_EN.

## Operation
- States: IDLE, WAIT, DRAIN, DONE.
- IDLE: tile_cnt=0, idx=0. start=1 → WAIT.
- WAIT: waits for core_valid all ones.
  - On that cycle, `in` is registered into cap_reg and core_ack=1 on the next cycle.
  - idx=0, then → DRAIN.
  - A partial core_valid never captures.
- DRAIN:
  - out_valid=1, out_data=cap_reg slice idx, out_core_idx=idx.
  - A handshake (out_valid & out_ready) with idx<NUM_CORES-1 sets idx+1.
  - A handshake with idx==NUM_CORES-1:
    - If tile_cnt<NUM_TILES-1: tile_cnt+1 → WAIT.
    - Otherwise → DONE.
  - out_last = (idx==NUM_CORES-1) && (tile_cnt==NUM_TILES-1) && out_valid.
- DONE: done=1 for exactly one cycle, then → IDLE.
- start outside IDLE is ignored.
- Counters wrap only by explicit reset to 0; tile_cnt width is $clog2(NUM_TILES)+1, so NUM_TILES=1 is legal.

## Timing
- Reset (asynchronous assert, synchronous release) drives all outputs low and all registers 0:
  - out_data=0, out_core_idx=0, core_ack=0, out_valid=0, out_last=0, busy=0, done=0, err=0.
  - State → IDLE.
- Reset mid-DRAIN discards the captured tile with no partial output afterwards.
- start at cycle t → busy=1 at t+1.
- All core_valid high at cycle t in WAIT → core_ack=1 and out_valid=1 with chunk 0 at t+1.
- Zero-stall drain: one chunk per cycle, so NUM_CORES cycles per tile.
- Minimum WAIT→WAIT turnaround is NUM_CORES+1 cycles.
- While out_valid=1 and out_ready=0, out_data, out_core_idx and out_last hold stable.
- out_valid never drops without a handshake.
- Final handshake at cycle t → done=1 at t+1, busy=0 and IDLE at t+2.
- out_ready is a don't-care when out_valid=0.

## Configuration
- SCHED_OVR_CHECK_EN defined:
  - err sets if any core_valid bit rises (0→1) during DRAIN. The cores must not produce a new result before the drain ends.
  - err stays set until rst_n.
  - Scheduling is unaffected.
- Undefined: err port absent, no detection logic.

## Test plan
- NUM_CORES=4, NUM_TILES=1, out_ready=1:
  - Stimulus: start, then core_valid=4'hF with core i data = {CHUNK_SIZE{16'h0i0i}}.
  - Required response: core_ack 1 cycle; chunks 0,1,2,3 on four consecutive cycles; out_last on idx 3; done one cycle later.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles at idx 1.
  - Required response: out_data and idx 1 stable throughout; no chunk lost or duplicated; total 7 drain cycles.
- NUM_TILES=3:
  - Stimulus: three capture rounds.
  - Required response: 12 chunks; out_last only on the 12th; done once.
- Partial valid:
  - Stimulus: core_valid=4'b0111 held 5 cycles, then 4'hF.
  - Required response: no capture or core_ack until 4'hF.
- Reset mid-operation:
  - Stimulus: rst_n low at idx 2 of tile 1, then start again.
  - Required response: all outputs 0 immediately; fresh run starts at tile 0, idx 0.
- With SCHED_OVR_CHECK_EN:
  - Stimulus: core_valid[2] pulses during DRAIN.
  - Required response: err=1 and sticky; chunk stream unchanged.
